// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//  Builds a 3x3 pixel window for each incoming pixel from the current-row pixel
//  and the two delayed-row taps of the line shifter. It aligns data0 with the
//  taps, replicates or zeroes the top rows and the left/right columns, and emits
//  one extra flush window after each line. As a result, de_o is high for as many
//  cycles per line as de_i.
//  Compile-time option: define BORDER_ZERO_EN to force out-of-frame rows and
//  columns to zero instead of replicating the nearest valid pixel.
module window_3x3_gen #(
    parameter int DW      = 8,
    parameter int TAP_LAT = 2,
    parameter int CW      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs_i,
    input  logic          de_i,
    input  logic [DW-1:0] data0_i,
    input  logic [DW-1:0] data1_i,
    input  logic [DW-1:0] data2_i,
    output logic          vs_o,
    output logic          de_o,
    output logic [DW-1:0] m11_o,
    output logic [DW-1:0] m12_o,
    output logic [DW-1:0] m13_o,
    output logic [DW-1:0] m21_o,
    output logic [DW-1:0] m22_o,
    output logic [DW-1:0] m23_o,
    output logic [DW-1:0] m31_o,
    output logic [DW-1:0] m32_o,
    output logic [DW-1:0] m33_o
);

    // ------------------------------------------------------------------
    // Align stage: data0/de/vs delayed TAP_LAT cycles to line up with taps
    // ------------------------------------------------------------------
    logic [DW-1:0] d0_dly_q [TAP_LAT];
    logic          de_dly_q [TAP_LAT];
    logic          vs_dly_q [TAP_LAT];

    logic [DW-1:0] data0_a;
    logic          de_a;
    logic          vs_a;

    assign data0_a = d0_dly_q[TAP_LAT-1];
    assign de_a    = de_dly_q[TAP_LAT-1];
    assign vs_a    = vs_dly_q[TAP_LAT-1];

    // Delay line for the current-row pixel and its strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAP_LAT; i++) begin
                d0_dly_q[i] <= '0;
                de_dly_q[i] <= 1'b0;
                vs_dly_q[i] <= 1'b0;
            end
        end else begin
            d0_dly_q[0] <= data0_i;
            de_dly_q[0] <= de_i;
            vs_dly_q[0] <= vs_i;
            for (int i = 1; i < TAP_LAT; i++) begin
                d0_dly_q[i] <= d0_dly_q[i-1];
                de_dly_q[i] <= de_dly_q[i-1];
                vs_dly_q[i] <= vs_dly_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Line / frame bookkeeping
    // ------------------------------------------------------------------
    logic          vs_a1_q;        // vs_a one cycle later (edge detect, vs_o chain)
    logic          vs_o_q;
    logic          de_a1_q;        // a column was shifted into the pipe last cycle
    logic [CW-1:0] col_cnt_q;      // columns shifted into the pipe this line
    logic [CW-1:0] col_cnt_d;
    logic [1:0]    row_cnt_q;      // completed lines this frame, saturating at 2
    logic [1:0]    row_cnt_d;
    logic          flush_q;        // this cycle produces the trailing flush window
    logic          flush_d;
    logic          flush_single_q; // the line being flushed had only one pixel
    logic          flush_single_d;

    logic          vs_rise;
    logic          de_fall;
    logic [1:0]    row_eff;        // row count seen by the column being formed

    assign vs_rise = vs_a & ~vs_a1_q;
    assign de_fall = de_a1_q & ~de_a;
    // A frame start mid-line takes effect on the very column that sees it
    assign row_eff = vs_rise ? 2'd0 : row_cnt_q;

    // Next-state logic for the column/row counters and flush control
    always_comb begin
        col_cnt_d      = '0;
        row_cnt_d      = row_cnt_q;
        flush_d        = de_fall;
        flush_single_d = (col_cnt_q == CW'(1));

        if (de_a) begin
            if (col_cnt_q == {CW{1'b1}}) begin
                col_cnt_d = col_cnt_q;
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end

        if (vs_rise) begin
            row_cnt_d = 2'd0;
        end else if (de_fall && (row_cnt_q != 2'd2)) begin
            row_cnt_d = row_cnt_q + 2'd1;
        end
    end

    // Bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_a1_q        <= 1'b0;
            vs_o_q         <= 1'b0;
            de_a1_q        <= 1'b0;
            col_cnt_q      <= '0;
            row_cnt_q      <= 2'd0;
            flush_q        <= 1'b0;
            flush_single_q <= 1'b0;
        end else begin
            vs_a1_q        <= vs_a;
            vs_o_q         <= vs_a1_q;
            de_a1_q        <= de_a;
            col_cnt_q      <= col_cnt_d;
            row_cnt_q      <= row_cnt_d;
            flush_q        <= flush_d;
            flush_single_q <= flush_single_d;
        end
    end

    // ------------------------------------------------------------------
    // Vertical edge handling: build the new column (index 0 = oldest row)
    // ------------------------------------------------------------------
    logic [DW-1:0] col_new [3];

    // Substitute missing upper rows while the frame's first two lines stream in
    always_comb begin
        col_new[0] = data2_i;
        col_new[1] = data1_i;
        col_new[2] = data0_a;
        if (row_eff == 2'd0) begin
`ifdef BORDER_ZERO_EN
            col_new[0] = '0;
            col_new[1] = '0;
`else
            col_new[0] = data0_a;
            col_new[1] = data0_a;
`endif
        end else if (row_eff == 2'd1) begin
`ifdef BORDER_ZERO_EN
            col_new[0] = '0;
`else
            col_new[0] = data1_i;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Column pipe: pipe_q[stage][row], stage 0 holds the newest column
    // ------------------------------------------------------------------
    logic [DW-1:0] pipe_q [3][3];

    // Shift one column in per aligned pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                for (int r = 0; r < 3; r++) begin
                    pipe_q[s][r] <= '0;
                end
            end
        end else if (de_a) begin
            for (int r = 0; r < 3; r++) begin
                pipe_q[2][r] <= pipe_q[1][r];
                pipe_q[1][r] <= pipe_q[0][r];
                pipe_q[0][r] <= col_new[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Window selection
    //  Normal: newest column is c, window centred on c-1 -> stages 2/1/0.
    //  Flush : no new column arrived, centre is the last column (stage 0).
    // ------------------------------------------------------------------
    logic          out_norm;
    logic          win_valid;
    logic          left_edge;
    logic [DW-1:0] left_w   [3];
    logic [DW-1:0] centre_w [3];
    logic [DW-1:0] right_w  [3];

    assign out_norm  = de_a1_q && (col_cnt_q >= CW'(2));
    assign win_valid = out_norm | flush_q;
    // Centre is column 0 when the pipe has just received column 1, or when a
    // single-pixel line is being flushed
    assign left_edge = flush_q ? flush_single_q : (col_cnt_q == CW'(2));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [DW-1:0] edge_val;

            assign centre_w[gi] = flush_q ? pipe_q[0][gi] : pipe_q[1][gi];
`ifdef BORDER_ZERO_EN
            assign edge_val = '0;
`else
            assign edge_val = centre_w[gi];
`endif
            assign right_w[gi] = flush_q ? edge_val : pipe_q[0][gi];
            assign left_w[gi]  = left_edge ? edge_val
                               : (flush_q ? pipe_q[1][gi] : pipe_q[2][gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers: m_q[row][col]; window held while de_o is low
    // ------------------------------------------------------------------
    logic [DW-1:0] m_q [3][3];
    logic          de_o_q;

    // Capture a new window only when one is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_o_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    m_q[r][c] <= '0;
                end
            end
        end else begin
            de_o_q <= win_valid;
            if (win_valid) begin
                for (int r = 0; r < 3; r++) begin
                    m_q[r][0] <= left_w[r];
                    m_q[r][1] <= centre_w[r];
                    m_q[r][2] <= right_w[r];
                end
            end
        end
    end

    assign vs_o  = vs_o_q;
    assign de_o  = de_o_q;
    assign m11_o = m_q[0][0];
    assign m12_o = m_q[0][1];
    assign m13_o = m_q[0][2];
    assign m21_o = m_q[1][0];
    assign m22_o = m_q[1][1];
    assign m23_o = m_q[1][2];
    assign m31_o = m_q[2][0];
    assign m32_o = m_q[2][1];
    assign m33_o = m_q[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen
//  Directed bench: 4x3 frame (pixel = row*16+col) plus a single-pixel line,
//  a reset in the middle of a line, and a repeat frame afterwards.
//  Expected windows follow BORDER_ZERO_EN when it is defined.
module tb_window_3x3_gen;

    localparam int DW      = 8;
    localparam int TAP_LAT = 2;
    localparam int CW      = 11;

`ifdef BORDER_ZERO_EN
    localparam logic [71:0] EXP_R0C0  = 72'h00_00_00_00_00_00_00_00_01;
    localparam logic [71:0] EXP_R1C2  = 72'h00_00_00_01_02_03_11_12_13;
    localparam logic [71:0] EXP_R2C1  = 72'h00_01_02_10_11_12_20_21_22;
    localparam logic [71:0] EXP_FLUSH = 72'h02_03_00_12_13_00_22_23_00;
    localparam logic [71:0] EXP_SINGLE= 72'h00_10_00_00_20_00_00_5A_00;
`else
    localparam logic [71:0] EXP_R0C0  = 72'h00_00_01_00_00_01_00_00_01;
    localparam logic [71:0] EXP_R1C2  = 72'h01_02_03_01_02_03_11_12_13;
    localparam logic [71:0] EXP_R2C1  = 72'h00_01_02_10_11_12_20_21_22;
    localparam logic [71:0] EXP_FLUSH = 72'h02_03_03_12_13_13_22_23_23;
    localparam logic [71:0] EXP_SINGLE= 72'h10_10_10_20_20_20_5A_5A_5A;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vs_i;
    logic          de_i;
    logic [DW-1:0] data0_i;
    logic [DW-1:0] data1_i;
    logic [DW-1:0] data2_i;
    logic          vs_o;
    logic          de_o;
    logic [DW-1:0] m11_o, m12_o, m13_o, m21_o, m22_o, m23_o, m31_o, m32_o, m33_o;

    window_3x3_gen #(.DW(DW), .TAP_LAT(TAP_LAT), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vs_i    (vs_i),
        .de_i    (de_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .vs_o    (vs_o),
        .de_o    (de_o),
        .m11_o   (m11_o),
        .m12_o   (m12_o),
        .m13_o   (m13_o),
        .m21_o   (m21_o),
        .m22_o   (m22_o),
        .m23_o   (m23_o),
        .m31_o   (m31_o),
        .m32_o   (m32_o),
        .m33_o   (m33_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [71:0] win;
    assign win = {m11_o, m12_o, m13_o, m21_o, m22_o, m23_o, m31_o, m32_o, m33_o};

    // Output monitor, sampled on the falling edge
    logic [71:0] out_win[$];
    int          out_cyc[$];
    int          vs_rise_cyc = -1;
    logic        vs_o_prev   = 1'b0;
    always @(negedge clk) begin
        if (de_o === 1'b1) begin
            out_win.push_back(win);
            out_cyc.push_back(cyc);
        end
        if (vs_o === 1'b1 && vs_o_prev === 1'b0) vs_rise_cyc = cyc;
        vs_o_prev = vs_o;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        if (r < 0) return 8'h00;
        return 8'((r * 16 + c) & 255);
    endfunction

    // Tap history: the row taps lag data0_i by TAP_LAT cycles
    bit h_de  [2] = '{0, 0};
    int h_row [2] = '{0, 0};
    int h_col [2] = '{0, 0};

    task automatic drive(input bit de, input int row, input int col, input logic [7:0] v0);
        de_i    = de;
        data0_i = de ? v0 : 8'h00;
        data1_i = h_de[1] ? pix(h_row[1] - 1, h_col[1]) : 8'h00;
        data2_i = h_de[1] ? pix(h_row[1] - 2, h_col[1]) : 8'h00;
        h_de[1]  = h_de[0];  h_row[1] = h_row[0]; h_col[1] = h_col[0];
        h_de[0]  = de;       h_row[0] = row;      h_col[0] = col;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 8'h00);
    endtask

    int col1_cyc;
    task automatic line(input int row, input int ncols, input int hblank);
        for (int c = 0; c < ncols; c++) begin
            if (c == 1) col1_cyc = cyc;
            drive(1'b1, row, c, pix(row, c));
        end
        idle(hblank);
    endtask

    int vs_cyc;
    int first_col1;
    task automatic vsync();
        vs_i   = 1'b1;
        vs_cyc = cyc;
        idle(2);
        vs_i   = 1'b0;
        idle(2);
    endtask

    initial begin
        rst_n   = 1'b0;
        vs_i    = 1'b0;
        de_i    = 1'b0;
        data0_i = '0;
        data1_i = '0;
        data2_i = '0;
        idle(3);
        chk("reset_strobes", 72'({de_o, vs_o}), 72'd0);
        chk("reset_window", win, 72'd0);
        rst_n = 1'b1;
        idle(2);

        // Frame 1: three 4-pixel rows, then a single-pixel row of value 5A
        out_win.delete();
        out_cyc.delete();
        vsync();
        line(0, 4, 4);
        first_col1 = col1_cyc;
        line(1, 4, 4);
        line(2, 4, 4);
        drive(1'b1, 3, 0, 8'h5A);
        idle(8);

        chk("f1_count", 72'(out_win.size()), 72'd13);
        chk("vs_latency", 72'(vs_rise_cyc - vs_cyc), 72'd4);
        chk("de_latency", 72'(out_cyc[0] - first_col1), 72'd4);
        chk("line0_span", 72'(out_cyc[3] - out_cyc[0]), 72'd3);
        chk("line_period", 72'(out_cyc[4] - out_cyc[0]), 72'd8);
        chk("r0_c0", out_win[0], EXP_R0C0);
        chk("r1_c2", out_win[6], EXP_R1C2);
        chk("r2_c1", out_win[9], EXP_R2C1);
        chk("r2_flush", out_win[11], EXP_FLUSH);
        chk("single_px", out_win[12], EXP_SINGLE);
        chk("hold_de", 72'(de_o), 72'd0);
        chk("hold_window", win, EXP_SINGLE);

        // Frame 2: reset lands in the middle of the first line
        vsync();
        out_win.delete();
        out_cyc.delete();
        drive(1'b1, 0, 0, pix(0, 0));
        drive(1'b1, 0, 1, pix(0, 1));
        rst_n = 1'b0;
        de_i  = 1'b0;
        #1;
        chk("midrst_strobes", 72'({de_o, vs_o}), 72'd0);
        chk("midrst_window", win, 72'd0);
        idle(3);
        rst_n = 1'b1;
        idle(8);
        chk("midrst_no_flush", 72'(out_win.size()), 72'd0);

        // Frame 3: clean frame after the reset
        vsync();
        line(0, 4, 4);
        first_col1 = col1_cyc;
        line(1, 4, 4);
        line(2, 4, 4);
        idle(4);
        chk("f3_count", 72'(out_win.size()), 72'd12);
        chk("f3_de_latency", 72'(out_cyc[0] - first_col1), 72'd4);
        chk("f3_r0_c0", out_win[0], EXP_R0C0);
        chk("f3_r2_c1", out_win[9], EXP_R2C1);
        chk("f3_r2_flush", out_win[11], EXP_FLUSH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
